// File: rtl/bias_ctrl_pkg.sv
// Shared definitions for the bias ROM read sequencer: FSM encoding, layer
// codes and the per-layer BASE/COUNT table.
package bias_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_HOLD      = 3'd2,
      ST_DONE      = 3'd3,
      ST_EXIT_WAIT = 3'd4
   } bias_state_e;

   localparam int unsigned LAYER_FIRST = 1;
   localparam int unsigned LAYER_LAST  = 5;

   function automatic logic is_layer(input logic [31:0] code);
      return (code >= LAYER_FIRST) && (code <= LAYER_LAST);
   endfunction

   // Bias words are packed back to back, so each BASE is the running sum of earlier COUNTs.
   function automatic logic [31:0] layer_base(input logic [31:0] code);
      case (code)
         32'd1:   return 32'd0;
         32'd2:   return 32'd2;
         32'd3:   return 32'd6;
         32'd4:   return 32'd14;
         32'd5:   return 32'd30;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] layer_count(input logic [31:0] code);
      case (code)
         32'd1:   return 32'd2;
         32'd2:   return 32'd4;
         32'd3:   return 32'd8;
         32'd4:   return 32'd16;
         32'd5:   return 32'd32;
         default: return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/bias_ctrl.sv
// Bias ROM read sequencer: walks one layer's bias words, one per consumer
// request, and pulses state_rst once the last word has been consumed.
//
// state      | meaning
// IDLE       | waiting for a conv layer code on current_state
// FETCH      | ROM read in flight (1-cycle registered read)
// HOLD       | word valid on the mux, waiting for bias_req
// DONE       | state_rst pulse cycle
// EXIT_WAIT  | layer finished, waiting for current_state to move off it
module bias_ctrl
   import bias_ctrl_pkg::*;
#(
   parameter int RD_ADDR_DEPTH = 9,
   parameter int STATE_WIDTH   = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [STATE_WIDTH-1:0]   current_state,
   input  logic                     bias_req,
   output logic [RD_ADDR_DEPTH-1:0] addr_rd,
   output logic                     bias_out_valid,
   output logic                     BiasMem_valid_out,
   output logic                     state_rst
);

   bias_state_e              state_q;
   logic [STATE_WIDTH-1:0]   layer_q;
   logic [RD_ADDR_DEPTH-1:0] addr_q;
   logic [RD_ADDR_DEPTH-1:0] cnt_q;
   logic                     valid_q;
   logic                     pulse_q;
   logic                     srst_q;

   logic [31:0]              cs_ext;
   logic [RD_ADDR_DEPTH-1:0] base_d;
   logic                     empty_d;
   logic [RD_ADDR_DEPTH-1:0] last_cnt_d;
   logic                     abort_d;

   assign cs_ext     = 32'(current_state);
   assign base_d     = RD_ADDR_DEPTH'(layer_base(cs_ext));
   assign empty_d    = (layer_count(cs_ext) == 32'd0);
   assign last_cnt_d = RD_ADDR_DEPTH'(layer_count(32'(layer_q)) - 32'd1);
   assign abort_d    = (current_state != layer_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         layer_q <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         pulse_q <= 1'b0;
         srst_q  <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         srst_q  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (is_layer(cs_ext)) begin
                  layer_q <= current_state;
                  addr_q  <= base_d;
                  cnt_q   <= '0;
                  if (empty_d) begin
                     state_q <= ST_DONE;
                     srst_q  <= 1'b1;
                  end else begin
                     state_q <= ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               if (abort_d) begin
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= ST_HOLD;
                  valid_q <= 1'b1;
                  pulse_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               // A layer change in the same cycle as a request abandons the layer.
               if (abort_d) begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
               end else if (bias_req) begin
                  valid_q <= 1'b0;
                  if (cnt_q == last_cnt_d) begin
                     state_q <= ST_DONE;
                     srst_q  <= 1'b1;
                  end else begin
                     addr_q  <= addr_q + 1'b1;
                     cnt_q   <= cnt_q + 1'b1;
                     state_q <= ST_FETCH;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_EXIT_WAIT;
            end
            ST_EXIT_WAIT: begin
               if (abort_d) state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign addr_rd           = addr_q;
   assign bias_out_valid    = valid_q;
   assign BiasMem_valid_out = pulse_q;
   assign state_rst         = srst_q;

endmodule

// File: tb/tb_bias_ctrl.sv
// Directed bench for bias_ctrl: reset, full layer, back-pressure, abort,
// stray requests and layer re-entry, with hand-computed expectations.
module tb_bias_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] current_state;
   logic       bias_req;
   logic [8:0] addr_rd;
   logic       bias_out_valid;
   logic       BiasMem_valid_out;
   logic       state_rst;

   int checks   = 0;
   int failures = 0;
   int pulses;

   bias_ctrl #(.RD_ADDR_DEPTH(9), .STATE_WIDTH(3)) dut (
      .clk               (clk),
      .rst               (rst),
      .current_state     (current_state),
      .bias_req          (bias_req),
      .addr_rd           (addr_rd),
      .bias_out_valid    (bias_out_valid),
      .BiasMem_valid_out (BiasMem_valid_out),
      .state_rst         (state_rst)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Outputs as a group: addr, valid level, first-cycle pulse, state_rst.
   task automatic chk_out(input string tag, input int a, input bit v, input bit p, input bit s);
      chk({tag, ".addr"},  32'(addr_rd), 32'(a));
      chk({tag, ".valid"}, 32'(bias_out_valid), 32'(v));
      chk({tag, ".pulse"}, 32'(BiasMem_valid_out), 32'(p));
      chk({tag, ".srst"},  32'(state_rst), 32'(s));
   endtask

   initial begin
      rst = 1'b1; current_state = 3'd2; bias_req = 1'b0;

      // Reset held 3 cycles with a layer code present
      tick(); tick(); tick();
      chk_out("reset", 0, 0, 0, 0);
      rst = 1'b0;
      tick();
      chk_out("post_rst_fetch", 2, 0, 0, 0);
      tick();
      chk_out("post_rst_hold", 2, 1, 1, 0);
      current_state = 3'd0;
      tick();
      chk_out("post_rst_abort", 2, 0, 0, 0);

      // Full layer L3: addresses 6..13
      current_state = 3'd3;
      tick();
      chk_out("l3_fetch0", 6, 0, 0, 0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_out("l3_hold", 6 + i, 1, 1, 0);
         if (BiasMem_valid_out) pulses++;
         bias_req = 1'b1;
         tick();
         bias_req = 1'b0;
         if (i < 7) chk_out("l3_fetch", 7 + i, 0, 0, 0);
         else       chk_out("l3_done", 13, 0, 0, 1);
      end
      chk("l3_pulses", 32'(pulses), 32'd8);

      // Stray requests in EXIT_WAIT then IDLE
      bias_req = 1'b1;
      tick();
      chk_out("l3_exit_wait", 13, 0, 0, 0);
      tick(); tick();
      chk_out("stray_exit_wait", 13, 0, 0, 0);
      current_state = 3'd0;
      tick();
      chk_out("stray_idle0", 13, 0, 0, 0);
      tick(); tick();
      chk_out("stray_idle1", 13, 0, 0, 0);
      bias_req = 1'b0;

      // Back-pressure on L1: 10 HOLD cycles, one pulse
      current_state = 3'd1;
      tick();
      chk_out("l1_fetch", 0, 0, 0, 0);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_out("l1_bp", 0, 1, (i == 0), 0);
         if (BiasMem_valid_out) pulses++;
      end
      chk("l1_bp_pulses", 32'(pulses), 32'd1);
      bias_req = 1'b1;
      tick();
      chk_out("l1_fetch1", 1, 0, 0, 0);
      // Request held through FETCH must be ignored, not queued
      tick();
      chk_out("l1_hold1", 1, 1, 1, 0);
      bias_req = 1'b0;
      tick();
      chk_out("l1_hold1_wait", 1, 1, 0, 0);
      bias_req = 1'b1;
      tick();
      chk_out("l1_done", 1, 0, 0, 1);
      tick();
      chk_out("l1_stray_done", 1, 0, 0, 0);
      bias_req = 1'b0;

      // Abort L4 after 5 words, simultaneous request
      current_state = 3'd0;
      tick();
      current_state = 3'd4;
      tick();
      chk_out("l4_fetch", 14, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_out("l4_hold", 14 + i, 1, 1, 0);
         bias_req = 1'b1;
         tick();
         bias_req = 1'b0;
      end
      tick();
      chk_out("l4_hold5", 19, 1, 1, 0);
      current_state = 3'd5;
      bias_req = 1'b1;
      tick();
      bias_req = 1'b0;
      chk_out("l4_abort", 19, 0, 0, 0);
      tick();
      chk_out("l5_fetch", 30, 0, 0, 0);
      pulses = 0;
      for (int i = 0; i < 32; i++) begin
         tick();
         chk_out("l5_hold", 30 + i, 1, 1, 0);
         pulses++;
         bias_req = 1'b1;
         tick();
         bias_req = 1'b0;
         if (i == 31) chk_out("l5_done", 61, 0, 0, 1);
      end
      chk("l5_words", 32'(pulses), 32'd32);
      tick();
      chk_out("l5_exit", 61, 0, 0, 0);

      // Re-entry: L2 held after completion does not restart
      current_state = 3'd0;
      tick();
      current_state = 3'd2;
      tick();
      chk_out("l2_fetch", 2, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_out("l2_hold", 2 + i, 1, 1, 0);
         bias_req = 1'b1;
         tick();
         bias_req = 1'b0;
      end
      chk_out("l2_done", 5, 0, 0, 1);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_out("l2_no_replay", 5, 0, 0, 0);
      end
      current_state = 3'd0;
      tick();
      current_state = 3'd2;
      tick();
      chk_out("l2_restart_fetch", 2, 0, 0, 0);
      tick();
      chk_out("l2_restart_hold", 2, 1, 1, 0);

      // Mid-layer reset wins over everything
      rst = 1'b1;
      bias_req = 1'b1;
      tick();
      chk_out("mid_reset", 0, 0, 0, 0);
      rst = 1'b0;
      bias_req = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
